// File: rtl/mux_2x1_pkg.sv
// mux_2x1_pkg -- shared constants and helpers for the mux_2x1 slice.
//   DEF_WIDTH   : default data width of a, b and y
//   DEF_CNT_W   : default width of the select-switch counter
//   sel_toggled : 1 when the sampled select differs from the previous sample
// Optional feature macro: MUX_2X1_SWCNT_EN (select-switch counter).
package mux_2x1_pkg;

  localparam int unsigned DEF_WIDTH = 32'd1;
  localparam int unsigned DEF_CNT_W = 32'd8;

  function automatic logic sel_toggled(input logic cur_sel, input logic prev_sel);
    return cur_sel ^ prev_sel;
  endfunction

endpackage : mux_2x1_pkg

// File: rtl/mux_2x1_if.sv
// mux_2x1_if -- data/select/enable bundle between a driver and mux_2x1.
//   a, b   : WIDTH-bit data inputs (a when sel=0, b when sel=1)
//   sel    : select
//   gbar   : active-low enable; 1 forces y to zero
//   y      : registered mux output
//   y_vld  : registered flag, y holds selected data
//   sw_cnt : select-switch count (only with MUX_2X1_SWCNT_EN)
// Modports: master drives the inputs, slave is the mux itself.
interface mux_2x1_if
  import mux_2x1_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             gbar;
  logic [WIDTH-1:0] y;
  logic             y_vld;
`ifdef MUX_2X1_SWCNT_EN
  logic [CNT_W-1:0] sw_cnt;

  modport master (output a, output b, output sel, output gbar,
                  input  y, input  y_vld, input sw_cnt);
  modport slave  (input  a, input  b, input  sel, input  gbar,
                  output y, output y_vld, output sw_cnt);
`else
  modport master (output a, output b, output sel, output gbar,
                  input  y, input  y_vld);
  modport slave  (input  a, input  b, input  sel, input  gbar,
                  output y, output y_vld);
`endif

endinterface : mux_2x1_if

// File: rtl/mux_2x1_sat_counter.sv
// sat_counter -- saturating up-counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears cnt
//   inc   : count enable, adds 1 unless already at all-ones
//   cnt   : registered count, sticks at 2^CNT_W-1
module sat_counter
  import mux_2x1_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // next count: hold at the all-ones ceiling instead of wrapping
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt = cnt_r;

endmodule : sat_counter

// File: rtl/mux_2x1.sv
// mux_2x1 -- registered 2:1 multiplexer with active-low enable.
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset (clears y, y_vld, counter state)
//   bus   : mux_2x1_if.slave (a, b, sel, gbar in; y, y_vld[, sw_cnt] out)
// y loads (sel ? b : a) when gbar=0 and zero when gbar=1, one cycle after
// sampling. With MUX_2X1_SWCNT_EN defined, sw_cnt counts enabled edges at
// which sel differs from its previous sample, saturating at 2^CNT_W-1.
module mux_2x1
  import mux_2x1_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_2x1_if.slave bus
);

  logic [WIDTH-1:0] y_r;
  logic             y_vld_r;
  logic [WIDTH-1:0] y_nxt_s;
  logic             y_vld_nxt_s;

  // select/enable datapath; gbar wins over any select activity
  always_comb begin
    y_nxt_s     = {WIDTH{1'b0}};
    y_vld_nxt_s = 1'b0;
    if (bus.gbar == 1'b0) begin
      y_nxt_s     = bus.sel ? bus.b : bus.a;
      y_vld_nxt_s = 1'b1;
    end else begin
      y_nxt_s     = {WIDTH{1'b0}};
      y_vld_nxt_s = 1'b0;
    end
  end

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r     <= {WIDTH{1'b0}};
      y_vld_r <= 1'b0;
    end else begin
      y_r     <= y_nxt_s;
      y_vld_r <= y_vld_nxt_s;
    end
  end

  assign bus.y     = y_r;
  assign bus.y_vld = y_vld_r;

`ifdef MUX_2X1_SWCNT_EN
  logic             prev_sel_r;
  logic             inc_s;
  logic [CNT_W-1:0] cnt_s;

  // previous-sel copy, refreshed at every edge whether enabled or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel_r <= 1'b0;
    end else begin
      prev_sel_r <= bus.sel;
    end
  end

  assign inc_s = (~bus.gbar) & sel_toggled(bus.sel, prev_sel_r);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_s),
    .cnt   (cnt_s)
  );

  assign bus.sw_cnt = cnt_s;
`endif

endmodule : mux_2x1

// File: tb/tb_mux_2x1.sv
// tb_mux_2x1 -- self-checking bench for mux_2x1 (WIDTH=8, CNT_W=2).
// Inputs change just after the falling edge; outputs are checked at the
// next falling edge against a reference computed from the mux rules.
module tb_mux_2x1;

  localparam int unsigned TW = 32'd8;
  localparam int unsigned TC = 32'd2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // reference state: last sampled sel and number of enabled sel switches
  logic m_prev;
  int   m_tog;
  logic [TW-1:0] exp_y;
  logic          exp_v;

  mux_2x1_if #(.WIDTH(TW), .CNT_W(TC)) bus ();

  mux_2x1 #(.WIDTH(TW), .CNT_W(TC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_y"}, {24'd0, bus.y}, {24'd0, exp_y});
    check({tag, "_vld"}, {31'd0, bus.y_vld}, {31'd0, exp_v});
`ifdef MUX_2X1_SWCNT_EN
    check({tag, "_cnt"}, {30'd0, bus.sw_cnt}, (m_tog > 3) ? 32'd3 : 32'(m_tog));
`endif
  endtask

  // one clock of stimulus: drive, predict, cross the rising edge, check
  task automatic step(input logic [TW-1:0] ia, input logic [TW-1:0] ib,
                      input logic isel, input logic ig, input string tag);
    bus.a    = ia;
    bus.b    = ib;
    bus.sel  = isel;
    bus.gbar = ig;
    if (ig) begin
      exp_y = 8'h00;
      exp_v = 1'b0;
    end else begin
      exp_y = isel ? ib : ia;
      exp_v = 1'b1;
      if (isel != m_prev) m_tog++;
    end
    m_prev = isel;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  // mid-cycle reset pulse that spans one rising edge
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    exp_y = 8'h00;
    exp_v = 1'b0;
    m_tog = 0;
    m_prev = 1'b0;
    check_outputs({tag, "_async"});
    @(negedge clk);
    check_outputs({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    int t;
    checks   = 0;
    errors   = 0;
    m_prev   = 1'b0;
    m_tog    = 0;
    rst_n    = 1'b0;
    bus.a    = 8'h01;
    bus.b    = 8'h01;
    bus.sel  = 1'b1;
    bus.gbar = 1'b0;
    #1;
    exp_y = 8'h00;
    exp_v = 1'b0;
    check_outputs("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // select: a=0, b=1
    step(8'h00, 8'h01, 1'b0, 1'b0, "sel0");
    step(8'h00, 8'h01, 1'b1, 1'b0, "sel1");

    // enable off with sel toggling, then re-enabled with sel=0
    for (int i = 0; i < 4; i++) begin
      step(8'h01, 8'h01, 1'(i % 2), 1'b1, "gbar_hi");
    end
    step(8'h01, 8'h01, 1'b0, 1'b0, "gbar_back");

    // full-width selection
    step(8'hA5, 8'h5A, 1'b1, 1'b0, "width_b");
    step(8'hA5, 8'h5A, 1'b0, 1'b0, "width_a");

    // inputs changed between edges must not reach y
    bus.a    = 8'hFF;
    bus.b    = 8'h00;
    bus.sel  = 1'b1;
    bus.gbar = 1'b1;
    #2;
    check_outputs("no_comb_path");

    // reset mid-operation with a=1,b=1,sel=1,gbar=0 pending
    step(8'h01, 8'h01, 1'b1, 1'b0, "pre_reset");
    pulse_reset("reset_mid");
    step(8'h01, 8'h01, 1'b1, 1'b0, "post_reset");

    // switch counter: toggles while disabled, then five enabled toggles
    pulse_reset("reset_cnt");
    step(8'h11, 8'h22, 1'b1, 1'b1, "cnt_off1");
    step(8'h11, 8'h22, 1'b0, 1'b1, "cnt_off2");
    for (int i = 0; i < 5; i++) begin
      step(8'h11, 8'h22, 1'((i + 1) % 2), 1'b0, "cnt_on");
    end
    step(8'h11, 8'h22, 1'b1, 1'b1, "cnt_sat_off");

    // randomized steps
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      step(ra, rb, 1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0), "rand");
    end

    // free-running square waves (time units, clock period 10)
    for (int c = 0; c < 64; c++) begin
      t = c * 10;
      step(((t % 100) >= 50) ? 8'hFF : 8'h00,
           ((t % 160) >= 80) ? 8'h3C : 8'h00,
           1'((t % 40) >= 20),
           1'((t % 60) >= 30),
           "free_run");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_2x1

// File: doc/mux_2x1.md
MUX_2X1 -- requirements
Module: mux_2x1

Interface
REQ-001 Parameter: WIDTH, default 1, data width of inputs a, b and output y.
REQ-002 Parameter: CNT_W, default 8, width of the select-switch counter (used only when MUX_2X1_SWCNT_EN is defined).
REQ-003 One clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: a  input  WIDTH  data input routed when sel=0.
REQ-007 Port: b  input  WIDTH  data input routed when sel=1.
REQ-008 Port: sel  input  1  select; 0 picks a, 1 picks b.
REQ-009 Port: gbar  input  1  active-low enable (strobe); 1 forces output to zero.
REQ-010 Port: y  output  WIDTH  registered mux output.
REQ-011 Port: y_vld  output  1  registered flag, 1 when y holds selected data (gbar was 0 at the previous edge).
REQ-012 Port: sw_cnt  output  CNT_W  count of sel toggles while enabled; present only with MUX_2X1_SWCNT_EN.

Function
REQ-013 At each rising clk edge with gbar=0, y SHALL load sel ? b : a; y_vld SHALL load 1.
REQ-014 At each rising clk edge with gbar=1, y SHALL load all-zeros and y_vld SHALL load 0, regardless of sel, a, b.
REQ-015 Latency SHALL be exactly one clk cycle from inputs to y/y_vld; no combinational path from any input to y.
REQ-016 sel, a, b, gbar SHALL be sampled only at the rising edge; changes between edges SHALL have no effect.
REQ-017 sel SHALL be treated as a single bit; any X/Z handling is outside scope (inputs are assumed driven, bench must drive known values).
REQ-018 All WIDTH bits SHALL be selected by the same sel; there is no per-bit select.
REQ-019 Simultaneous gbar and sel change at one edge: the new gbar value SHALL take priority (gbar=1 -> zero output).

Reset
REQ-020 rst_n=0 SHALL immediately (without clk) force y=0, y_vld=0, and sw_cnt=0 and a registered previous-sel copy to 0.
REQ-021 Release of rst_n SHALL be synchronous to clk at the design level; the first update occurs at the first rising edge with rst_n=1.
REQ-022 Reset asserted mid-operation SHALL discard the pending value; no output state survives reset.

Configuration
REQ-023 Macro MUX_2X1_SWCNT_EN defined: sw_cnt port and counter exist; counter SHALL increment by 1 at each edge where gbar=0 and sel differs from the sel sampled at the previous edge, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-024 Macro MUX_2X1_SWCNT_EN undefined: sw_cnt port, counter and previous-sel register SHALL be absent; all other behaviour unchanged.

Structure
REQ-025 A shared package mux_2x1_pkg SHALL hold the default constants DEF_WIDTH=1 and DEF_CNT_W=8.
REQ-026 The saturating counter SHALL be a sub-module sat_counter (parameter CNT_W; inputs clk, rst_n, inc; output cnt).
REQ-027 The top SHALL contain only the select/enable datapath, output registers and the optional sat_counter instance.

Verification
REQ-028 Reset: rst_n=0 with a=1,b=1,sel=1,gbar=0 -> y=0, y_vld=0 immediately, without a clk edge.
REQ-029 Select: gbar=0, a=0, b=1; sel=0 then sel=1 on successive edges -> y=0 then y=1, each one cycle after sampling, y_vld=1.
REQ-030 Enable: gbar=1, a=1, b=1, sel toggling each cycle -> y=0, y_vld=0 on every edge; gbar back to 0 with sel=0 -> y=1 next cycle.
REQ-031 Width: WIDTH=8, a=8'hA5, b=8'h5A, gbar=0, sel=1 -> y=8'h5A after one edge; sel=0 -> y=8'hA5.
REQ-032 Counter (macro on, CNT_W=2): sel toggled 5 times with gbar=0 -> sw_cnt=3 (saturated); toggles with gbar=1 -> no increment.
REQ-033 Free-running: gbar period 60, sel period 40, a period 100, b period 160 (time units, clk period 10) -> y equals zero-or-mux reference delayed one cycle at every edge.
